array_min_scanner: RTL and testbench

- Hardware accelerator sitting directly upstream of the data memory, sharing its single word port.
- On `start`, it reads a contiguous array of 32-bit little-endian words from data memory and finds the signed minimum and the index of that minimum.
- It writes the minimum to word address RESULT_ADR and the index to RESULT_ADR+4, which the memory exposes as its `min` / `min_idx` observation outputs.
- It replaces the software min loop.

---
 rtl/min_scan_pkg.sv | 20 ++
 rtl/scan_cmp_reg.sv | 36 +++
 rtl/array_min_scanner.sv | 146 ++++++++++++++
 tb/tb_array_min_scanner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/min_scan_pkg.sv
// Shared types and constants for the array minimum scanner.
package min_scan_pkg;

  localparam int          DATA_W      = 32;
  localparam logic [31:0] WORD_STRIDE = 32'd4;
  localparam logic [31:0] IDX_OFS     = 32'd4;
  localparam logic [31:0] MAX_OFS     = 32'd8;
  localparam logic [31:0] MAXIDX_OFS  = 32'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WR_MIN,
    ST_WR_IDX,
    ST_WR_MAX,
    ST_WR_MAXIDX,
    ST_DONE
  } state_t;

endpackage

// File: rtl/scan_cmp_reg.sv
// Running best-value register: keeps the signed min (or max) seen so far and its index.
module scan_cmp_reg
  import min_scan_pkg::*;
#(
  parameter bit SEL_MAX = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     first,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] sample,
  input  logic        [CNT_W-1:0]  idx,
  output logic signed [DATA_W-1:0] best,
  output logic        [CNT_W-1:0]  best_idx
);

  logic better;

  // Strict compare so ties keep the earliest index.
  always_comb begin
    if (SEL_MAX) better = (sample > best);
    else         better = (sample < best);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best     <= '0;
      best_idx <= '0;
    end else if (valid && (first || better)) begin
      best     <= sample;
      best_idx <= idx;
    end
  end

endmodule

// File: rtl/array_min_scanner.sv
// Scans a word array in data memory for its signed minimum and writes value/index back.
// Define MIN_SCAN_MAX_EN to also track the signed maximum and write it after the min results.
module array_min_scanner
  import min_scan_pkg::*;
#(
  parameter logic [31:0] RESULT_ADR = 32'd2000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] count,
  output logic [31:0]      mem_adr,
  output logic [31:0]      mem_wdata,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic             done
);

  state_t state, state_nxt;

  logic [31:0]              base_q;
  logic [CNT_W-1:0]         count_q;
  logic [CNT_W-1:0]         ptr;
  logic [CNT_W-1:0]         last_ptr;
  logic                     scan_vld;
  logic                     scan_first;
  logic signed [DATA_W-1:0] rd_sample;
  logic signed [DATA_W-1:0] min_val;
  logic [CNT_W-1:0]         min_idx;

  assign rd_sample  = mem_rdata;
  assign last_ptr   = count_q - CNT_W'(1);
  assign scan_vld   = (state == ST_SCAN);
  assign scan_first = scan_vld && (ptr == '0);

  scan_cmp_reg #(.SEL_MAX(1'b0), .CNT_W(CNT_W)) u_min (
    .clk      (clk),
    .rst      (rst),
    .first    (scan_first),
    .valid    (scan_vld),
    .sample   (rd_sample),
    .idx      (ptr),
    .best     (min_val),
    .best_idx (min_idx)
  );

`ifdef MIN_SCAN_MAX_EN
  logic signed [DATA_W-1:0] max_val;
  logic [CNT_W-1:0]         max_idx;

  scan_cmp_reg #(.SEL_MAX(1'b1), .CNT_W(CNT_W)) u_max (
    .clk      (clk),
    .rst      (rst),
    .first    (scan_first),
    .valid    (scan_vld),
    .sample   (rd_sample),
    .idx      (ptr),
    .best     (max_val),
    .best_idx (max_idx)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) ptr <= '0;
      else if (state == ST_SCAN)     ptr <= ptr + CNT_W'(1);
    end
  end

  // Request parameters are plain data: captured on acceptance, never reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      base_q  <= base_adr;
      count_q <= count;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_adr   = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (count != '0) ? ST_SCAN : ST_DONE;
      end
      ST_SCAN: begin
        busy    = 1'b1;
        mem_rd  = 1'b1;
        mem_adr = base_q + 32'(ptr) * WORD_STRIDE;
        if (ptr == last_ptr) state_nxt = ST_WR_MIN;
      end
      ST_WR_MIN: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_adr   = RESULT_ADR;
        mem_wdata = min_val;
        state_nxt = ST_WR_IDX;
      end
      ST_WR_IDX: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_adr   = RESULT_ADR + IDX_OFS;
        mem_wdata = 32'(min_idx);
`ifdef MIN_SCAN_MAX_EN
        state_nxt = ST_WR_MAX;
`else
        state_nxt = ST_DONE;
`endif
      end
`ifdef MIN_SCAN_MAX_EN
      ST_WR_MAX: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_adr   = RESULT_ADR + MAX_OFS;
        mem_wdata = max_val;
        state_nxt = ST_WR_MAXIDX;
      end
      ST_WR_MAXIDX: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_adr   = RESULT_ADR + MAXIDX_OFS;
        mem_wdata = 32'(max_idx);
        state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_array_min_scanner.sv
// Randomised bench for array_min_scanner with a queue-based per-cycle reference model.
module tb_array_min_scanner;

  localparam logic [31:0] RES = 32'd2000;
`ifdef MIN_SCAN_MAX_EN
  localparam int NWR = 4;
`else
  localparam int NWR = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] base_adr;
  logic [15:0] count;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, busy, done;

  logic [31:0] mem     [0:255];
  logic [31:0] res_mem [0:3];
  int          wr_cycles = 0;
  int          stray_wr  = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        busy;
    logic        done;
    logic [31:0] adr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] vals[$];
  logic [31:0] rd_log[$];
  int          nvec = 0, nerr = 0;
  int          last_wr_delta;
  bit          chk_en = 1'b0;

  array_min_scanner #(.RESULT_ADR(RES), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_adr  (base_adr),
    .count     (count),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // 1 KB aliased data memory for reads; result words captured separately.
  assign mem_rdata = mem[mem_adr[9:2]];

  always @(posedge clk) begin
    if (mem_wr) begin
      wr_cycles <= wr_cycles + 1;
      case (mem_adr)
        RES:          res_mem[0] <= mem_wdata;
        RES + 32'd4:  res_mem[1] <= mem_wdata;
        RES + 32'd8:  res_mem[2] <= mem_wdata;
        RES + 32'd12: res_mem[3] <= mem_wdata;
        default:      stray_wr   <= stray_wr + 1;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic rd, input logic wr, input logic bsy,
                              input logic dn, input logic [31:0] adr, input logic [31:0] wd);
    exp_t e;
    e.rd = rd; e.wr = wr; e.busy = bsy; e.done = dn; e.adr = adr; e.wdata = wd;
    return e;
  endfunction

  // Per-cycle compare: expected record if one is queued, otherwise quiescent idle.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("mem_rd", 32'(mem_rd), 32'(e.rd));
      check("mem_wr", 32'(mem_wr), 32'(e.wr));
      check("busy",   32'(busy),   32'(e.busy));
      check("done",   32'(done),   32'(e.done));
      if (e.rd || e.wr) check("mem_adr", mem_adr, e.adr);
      if (e.wr)         check("mem_wdata", mem_wdata, e.wdata);
    end
  end

  // Reference: extreme value first, then the earliest position holding it.
  function automatic void extreme(input bit want_max, output logic [31:0] v, output int pos);
    v = vals[0];
    foreach (vals[i])
      if (want_max ? ($signed(vals[i]) > $signed(v)) : ($signed(vals[i]) < $signed(v)))
        v = vals[i];
    pos = -1;
    foreach (vals[i])
      if (pos < 0 && vals[i] == v) pos = i;
  endfunction

  // Called at posedge+#1. glitch_cyc/rst_cyc = 0 disables the extra start / mid-scan reset.
  task automatic run_scan(input logic [31:0] base, input int glitch_cyc, input int rst_cyc,
                          output int done_cyc);
    int          n = vals.size();
    int          cyc = 0;
    int          wr0;
    int          mn_i, mx_i;
    logic [31:0] a, mn, mx;
    mn = 32'd0; mx = 32'd0; mn_i = 0; mx_i = 0;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      mem[a[9:2]] = vals[i];
    end
    if (n > 0) begin
      extreme(1'b0, mn, mn_i);
      extreme(1'b1, mx, mx_i);
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    for (int i = 0; i < n; i++)
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, base + 32'(4 * i), 32'd0));
    if (n > 0) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, RES, mn));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, RES + 32'd4, 32'(mn_i)));
`ifdef MIN_SCAN_MAX_EN
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, RES + 32'd8, mx));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, RES + 32'd12, 32'(mx_i)));
`endif
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0));

    rd_log.delete();
    wr0      = wr_cycles;
    base_adr = base;
    count    = 16'(n);
    start    = 1'b1;
    done_cyc = -1;
    for (int k = 0; k < n + 12; k++) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == glitch_cyc);
      if (cyc == glitch_cyc) begin
        base_adr = 32'h40;
        count    = 16'd5;
      end
      rst = (cyc == rst_cyc);
      if (cyc == rst_cyc)
        while (exp_q.size() > 1) void'(exp_q.pop_back());
      @(negedge clk);
      if (mem_rd) rd_log.push_back(mem_adr);
      if (done && done_cyc < 0) done_cyc = cyc;
    end
    @(posedge clk); #1;
    last_wr_delta = wr_cycles - wr0;

    if (rst_cyc == 0) begin
      check("done_cycle", 32'(done_cyc), (n == 0) ? 32'd1 : 32'(n + 1 + NWR));
      check("write_cycles", 32'(last_wr_delta), (n == 0) ? 32'd0 : 32'(NWR));
      if (n > 0) begin
        check("result_min", res_mem[0], mn);
        check("result_idx", res_mem[1], 32'(mn_i));
`ifdef MIN_SCAN_MAX_EN
        check("result_max", res_mem[2], mx);
        check("result_maxidx", res_mem[3], 32'(mx_i));
`endif
      end
    end else begin
      check("no_done_after_rst", 32'(done_cyc), 32'hFFFF_FFFF);
      check("no_write_after_rst", 32'(last_wr_delta), 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] pick[4];
    pick[0] = 32'h8000_0000; pick[1] = 32'h7FFF_FFFF; pick[2] = 32'h0; pick[3] = 32'hFFFF_FFFF;
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 3));
      2:       return 32'($urandom_range(0, 7)) - 32'd4;
      default: return pick[$urandom_range(0, 3)];
    endcase
  endfunction

  initial begin
    int          dc;
    logic [31:0] r0;
    rst = 1'b1; start = 1'b0; base_adr = '0; count = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  32'(busy),   32'd0);
    check("rst_done",  32'(done),   32'd0);
    check("rst_rd",    32'(mem_rd), 32'd0);
    check("rst_wr",    32'(mem_wr), 32'd0);
    check("rst_adr",   mem_adr,     32'd0);
    check("rst_wdata", mem_wdata,   32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Basic array
    vals = '{32'd7, 32'd3, 32'd9, 32'd3};
    run_scan(32'd0, 0, 0, dc);
    check("basic_min", res_mem[0], 32'd3);
    check("basic_idx", res_mem[1], 32'd1);
`ifdef MIN_SCAN_MAX_EN
    check("basic_done_cyc", 32'(dc), 32'd9);
    check("basic_wr_cnt", 32'(last_wr_delta), 32'd4);
    check("basic_max", res_mem[2], 32'd9);
    check("basic_maxidx", res_mem[3], 32'd2);
`else
    check("basic_done_cyc", 32'(dc), 32'd7);
    check("basic_wr_cnt", 32'(last_wr_delta), 32'd2);
`endif

    // Start pulse during SCAN must be ignored
    run_scan(32'd0, 2, 0, dc);
    check("ignore_min", res_mem[0], 32'd3);
    check("ignore_idx", res_mem[1], 32'd1);

    // Reset mid-scan, then a clean run
    vals.delete();
    for (int i = 0; i < 10; i++) vals.push_back(rand_val());
    run_scan(32'h20, 0, 4, dc);
    vals = '{32'd5, 32'hFFFF_FFFE, 32'h8000_0000, 32'd4};
    run_scan(32'h100, 0, 0, dc);
    check("signed_min", res_mem[0], 32'h8000_0000);
    check("signed_idx", res_mem[1], 32'd2);

    // Address wrap
    vals = '{32'd11, 32'd10, 32'd12};
    run_scan(32'hFFFF_FFF8, 0, 0, dc);
    check("wrap_adr0", (rd_log.size() > 0) ? rd_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    check("wrap_adr1", (rd_log.size() > 1) ? rd_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("wrap_adr2", (rd_log.size() > 2) ? rd_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);
    check("wrap_min", res_mem[0], 32'd10);

    // Empty array
    r0 = res_mem[0];
    vals.delete();
    run_scan(32'h40, 0, 0, dc);
    check("empty_done_cyc", 32'(dc), 32'd1);
    check("empty_mem_kept", res_mem[0], r0);

    // Randomised arrays
    for (int t = 0; t < 25; t++) begin
      vals.delete();
      for (int i = 0; i < int'($urandom_range(1, 32)); i++) vals.push_back(rand_val());
      run_scan(32'(4 * $urandom_range(0, 100)), 0, 0, dc);
    end

    check("stray_writes", 32'(stray_wr), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
